riscv_commit_trace: RTL

- Consumes the writeback/debug stream that riscv_pipeline_top exposes (debug_pc, debug_instr, debug_reg_we/addr/data).
- Captures each retired register write into a sequence-numbered trace FIFO.
- Drains the FIFO over a valid/ready port, for the testbench scoreboard or a future UART/trace dumper.
- Detects and counts overflow so lost commits are never silent.

---
 rtl/riscv_trace_pkg.sv | 17 +
 rtl/riscv_commit_trace_if.sv | 37 +++
 rtl/riscv_trace_fifo.sv | 53 +++++
 rtl/riscv_commit_trace.sv | 103 ++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared types for the commit trace block: the widths of the architectural fields
// and the default packed layout of one trace entry.
package riscv_trace_pkg;

  localparam int XLEN        = 32;
  localparam int REG_AW      = 5;
  localparam int TRACE_SEQ_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic [REG_AW-1:0]      rd;
    logic [XLEN-1:0]        data;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/riscv_commit_trace_if.sv
// Drain port of the commit trace FIFO, plus its occupancy and overflow status.
// The master drives the head entry and status; the slave drives trace_ready.
interface riscv_commit_trace_if
  import riscv_trace_pkg::*;
#(
  parameter int SEQ_W  = 16,
  parameter int CNT_W  = 5,
  parameter int DROP_W = 8
);

  // Handshake: the head entry transfers on a rising edge where trace_valid and
  // trace_ready are both 1. While trace_valid=1 and trace_ready=0 the head fields
  // hold stable; trace_valid never depends combinationally on trace_ready.
  logic              trace_valid;
  logic              trace_ready;
  logic [XLEN-1:0]   trace_pc;
  logic [XLEN-1:0]   trace_instr;
  logic [REG_AW-1:0] trace_rd;
  logic [XLEN-1:0]   trace_data;
  logic [SEQ_W-1:0]  trace_seq;
  logic [CNT_W-1:0]  trace_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output trace_valid, trace_pc, trace_instr, trace_rd, trace_data, trace_seq,
    output trace_count, overflow, drop_cnt,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_instr, trace_rd, trace_data, trace_seq,
    input  trace_count, overflow, drop_cnt,
    output trace_ready
  );

endinterface

// File: rtl/riscv_trace_fifo.sv
// Synchronous FIFO of trace entries. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy register.
module riscv_trace_fifo
  import riscv_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  entry_t      wdata,
  output entry_t      rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_pop  = pop & ~empty & ~clr & ~rst;
  assign do_push = push & (~full | do_pop) & ~clr & ~rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head is forced to zero while empty so stale slots never leak out.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_commit_trace.sv
// Captures retired register writes into a sequence-numbered trace FIFO and
// counts dropped captures. Optional macro TRACE_X0_FILTER_EN skips rd==0 writes.
module riscv_commit_trace
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_en,
  input  logic              trace_clr,
  input  logic [XLEN-1:0]   debug_pc,
  input  logic [XLEN-1:0]   debug_instr,
  input  logic              debug_reg_we,
  input  logic [REG_AW-1:0] debug_reg_addr,
  input  logic [XLEN-1:0]   debug_reg_data,
  riscv_commit_trace_if.master trace
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  logic              cap;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [SEQ_W-1:0]  seq;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;
  entry_t            wr_entry;
  entry_t            head;

`ifdef TRACE_X0_FILTER_EN
  assign cap = trace_en & debug_reg_we & (debug_reg_addr != '0);
`else
  assign cap = trace_en & debug_reg_we;
`endif

  assign pop    = trace.trace_valid & trace.trace_ready;
  assign accept = cap & (~full | pop);
  assign drop   = cap & full & ~pop;

  assign wr_entry = '{pc:    debug_pc,
                      instr: debug_instr,
                      rd:    debug_reg_addr,
                      data:  debug_reg_data,
                      seq:   seq};

  riscv_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (trace_clr),
    .push  (cap),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // seq only advances for entries that actually land in the FIFO, so gaps in the
  // drained sequence never appear; lost commits show up in drop_cnt instead.
  always_ff @(posedge clk) begin
    if (rst || trace_clr) begin
      seq        <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (accept) seq <= seq + SEQ_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  assign trace.trace_valid = ~empty;
  assign trace.trace_pc    = head.pc;
  assign trace.trace_instr = head.instr;
  assign trace.trace_rd    = head.rd;
  assign trace.trace_data  = head.data;
  assign trace.trace_seq   = head.seq;
  assign trace.trace_count = count;
  assign trace.overflow    = overflow_q;
  assign trace.drop_cnt    = drop_q;

endmodule
